// File: rtl/scan_pkg.sv
// Shared types for the window scan controller: shift directions and FSM states.
package scan_pkg;

    typedef enum logic [1:0] {
        DIR_HOLD  = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_DOWN  = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EVAL  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Priming counter value once all three initial column strips are loaded
    localparam logic [1:0] PRIME_DONE = 2'd3;

endpackage

// File: rtl/window_scan_ctrl_if.sv
// Strip fetch handshake between the scan controller and the pixel source.
interface window_scan_ctrl_if #(
    parameter int CW = 6
);
    logic          fetch_req;
    logic [CW-1:0] fetch_x;
    logic [CW-1:0] fetch_y;
    logic          fetch_vert;
    logic          fetch_ack;

    modport master (
        output fetch_req,
        output fetch_x,
        output fetch_y,
        output fetch_vert,
        input  fetch_ack
    );

    modport slave (
        input  fetch_req,
        input  fetch_x,
        input  fetch_y,
        input  fetch_vert,
        output fetch_ack
    );
endinterface

// File: rtl/scan_coord_gen.sv
// Centre counters, serpentine pass direction, row-end detection and strip address generation.
module scan_coord_gen
    import scan_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int CW    = 6
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          clear,
    input  logic          advance,
    output logic [CW-1:0] fetch_x,
    output logic [CW-1:0] fetch_y,
    output logic          fetch_vert,
    output dir_t          fetch_dir,
    output logic [CW-1:0] center_x,
    output logic [CW-1:0] center_y,
    output logic          win_full,
    output logic          last_pixel
);

    localparam logic [CW-1:0] ONE   = CW'(1);
    localparam logic [CW-1:0] TWO   = CW'(2);
    localparam logic [CW-1:0] X_END = CW'(IMG_W - 2);
    localparam logic [CW-1:0] Y_END = CW'(IMG_H - 2);

    logic [1:0] prime_cnt;
    logic       pass_left;
    logic       primed;
    logic       row_end;

    assign primed     = (prime_cnt == PRIME_DONE);
    // The third priming strip (count 2) already completes the window
    assign win_full   = prime_cnt[1];
    assign row_end    = primed && (pass_left ? (center_x == ONE) : (center_x == X_END));
    assign last_pixel = row_end && (center_y == Y_END);

    always_comb begin
        fetch_x    = '0;
        fetch_y    = '0;
        fetch_vert = 1'b1;
        fetch_dir  = DIR_RIGHT;
        if (!primed) begin
            fetch_x = CW'(prime_cnt);
        end else if (row_end) begin
            fetch_x    = center_x - ONE;
            fetch_y    = center_y + TWO;
            fetch_vert = 1'b0;
            fetch_dir  = DIR_DOWN;
        end else if (pass_left) begin
            fetch_x   = center_x - TWO;
            fetch_y   = center_y - ONE;
            fetch_dir = DIR_LEFT;
        end else begin
            fetch_x = center_x + TWO;
            fetch_y = center_y - ONE;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            prime_cnt <= '0;
            pass_left <= 1'b0;
            center_x  <= '0;
            center_y  <= '0;
        end else if (clear) begin
            prime_cnt <= '0;
            pass_left <= 1'b0;
            center_x  <= '0;
            center_y  <= '0;
        end else if (advance) begin
            if (prime_cnt == 2'd2) begin
                prime_cnt <= PRIME_DONE;
                center_x  <= ONE;
                center_y  <= ONE;
            end else if (!primed) begin
                prime_cnt <= prime_cnt + 2'd1;
            end else if (row_end) begin
                center_y  <= center_y + ONE;
                pass_left <= ~pass_left;
            end else if (pass_left) begin
                center_x <= center_x - ONE;
            end else begin
                center_x <= center_x + ONE;
            end
        end
    end

endmodule

// File: rtl/window_scan_ctrl.sv
// Serpentine 3x3 window scan controller: fetch handshake, shift strobes and hysteresis sequencing.
module window_scan_ctrl
    import scan_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int CW    = $clog2((IMG_W > IMG_H) ? IMG_W : IMG_H)
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    window_scan_ctrl_if.master  fetch_if,
    output logic                shift_enable,
    output logic [1:0]          shift_direction,
    output logic                hysteresis_enable,
    output logic [CW-1:0]       center_x,
    output logic [CW-1:0]       center_y,
    output logic                pix_valid
);

    state_t        state;
    state_t        state_nxt;
    logic          clear;
    logic          req_c;
    logic          shift_c;
    logic          hyst_c;
    logic [CW-1:0] gen_x;
    logic [CW-1:0] gen_y;
    logic          gen_vert;
    dir_t          gen_dir;
    logic          win_full;
    logic          last_pixel;

    scan_coord_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .CW    (CW)
    ) u_coord (
        .clk        (clk),
        .n_rst      (n_rst),
        .clear      (clear),
        .advance    (shift_c),
        .fetch_x    (gen_x),
        .fetch_y    (gen_y),
        .fetch_vert (gen_vert),
        .fetch_dir  (gen_dir),
        .center_x   (center_x),
        .center_y   (center_y),
        .win_full   (win_full),
        .last_pixel (last_pixel)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        req_c     = 1'b0;
        shift_c   = 1'b0;
        hyst_c    = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    clear     = 1'b1;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                req_c = 1'b1;
                if (fetch_if.fetch_ack) begin
                    shift_c   = 1'b1;
                    state_nxt = win_full ? EVAL : FETCH;
                end
            end
            EVAL: begin
                hyst_c    = 1'b1;
                state_nxt = last_pixel ? DONE : FETCH;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Address lines read as zero whenever no request is outstanding
    assign fetch_if.fetch_req  = req_c;
    assign fetch_if.fetch_x    = req_c ? gen_x : '0;
    assign fetch_if.fetch_y    = req_c ? gen_y : '0;
    assign fetch_if.fetch_vert = req_c & gen_vert;

    assign shift_enable      = shift_c;
    assign shift_direction   = shift_c ? gen_dir : DIR_HOLD;
    assign hysteresis_enable = hyst_c;

    // Result of the EVAL cycle emerges one cycle later, centre still unchanged
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) pix_valid <= 1'b0;
        else        pix_valid <= hyst_c;
    end

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Bench for window_scan_ctrl: fixed tables for 5x4, corner sequences, randomized 7x6 frames vs. a scan-order model.
module tb_window_scan_ctrl;
    import scan_pkg::*;

    localparam int NI  = 3;
    localparam int CWT = 4;

    typedef struct { int x; int y; int vert; int dir; } fetch_t;
    typedef struct { int x; int y; } pix_t;
    typedef struct { int idx; int x; int y; int vert; int dir; } fvec_t;
    typedef struct { int idx; int x; int y; } pvec_t;

    logic tb_clk = 1'b0;
    logic n_rst;
    always #5 tb_clk = ~tb_clk;

    logic           start [NI];
    logic           busy  [NI];
    logic           done  [NI];
    logic           sh_en [NI];
    logic [1:0]     sh_dir[NI];
    logic           hen   [NI];
    logic [CWT-1:0] cxo   [NI];
    logic [CWT-1:0] cyo   [NI];
    logic           pv    [NI];
    logic           req   [NI];
    logic [CWT-1:0] fx    [NI];
    logic [CWT-1:0] fy    [NI];
    logic           fv    [NI];
    logic           ack   [NI];
    logic           ack_r [NI];
    logic           spur  [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int W = (g == 0) ? 5 : (g == 1) ? 3 : 7;
        localparam int H = (g == 0) ? 4 : (g == 1) ? 3 : 6;
        window_scan_ctrl_if #(.CW(CWT)) fif ();
        assign fif.fetch_ack = ack_r[g] | spur[g];
        assign ack[g] = fif.fetch_ack;
        assign req[g] = fif.fetch_req;
        assign fx[g]  = fif.fetch_x;
        assign fy[g]  = fif.fetch_y;
        assign fv[g]  = fif.fetch_vert;
        window_scan_ctrl #(.IMG_W(W), .IMG_H(H), .CW(CWT)) u_dut (
            .clk               (tb_clk),
            .n_rst             (n_rst),
            .start             (start[g]),
            .busy              (busy[g]),
            .done              (done[g]),
            .fetch_if          (fif.master),
            .shift_enable      (sh_en[g]),
            .shift_direction   (sh_dir[g]),
            .hysteresis_enable (hen[g]),
            .center_x          (cxo[g]),
            .center_y          (cyo[g]),
            .pix_valid         (pv[g])
        );
    end

    int act = 0;
    int fixed_lat = 0, cur_lat = 0, wcnt = 0;
    bit rnd_lat = 0;
    int cyc = 0;
    int n_tests = 0, n_fail = 0;

    fetch_t fq[$];
    pix_t   pq[$];
    int     ack_cyc[$], hen_cyc[$], pv_cyc[$];
    int     n_shift, n_done, done_pix, done_cyc, stab_err;
    bit     prev_wait;
    logic [2*CWT:0] prev_addr;

    fetch_t exp_f[$];
    pix_t   exp_p[$];

    always @(posedge tb_clk) cyc <= cyc + 1;

    // Pixel source: acknowledges each request after cur_lat waiting cycles
    initial begin
        forever begin
            @(posedge tb_clk);
            #1;
            for (int i = 0; i < NI; i++) ack_r[i] = 1'b0;
            if (n_rst === 1'b1 && req[act] === 1'b1) begin
                if (wcnt >= cur_lat) begin
                    ack_r[act] = 1'b1;
                    wcnt = 0;
                    cur_lat = rnd_lat ? int'($urandom_range(0, 4)) : fixed_lat;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    always @(negedge tb_clk) begin
        int a;
        fetch_t r;
        pix_t p;
        a = act;
        if (req[a] === 1'b1 && ack[a] === 1'b1) begin
            r.x = int'(fx[a]); r.y = int'(fy[a]); r.vert = int'(fv[a]); r.dir = int'(sh_dir[a]);
            fq.push_back(r);
            ack_cyc.push_back(cyc);
        end
        if (sh_en[a] === 1'b1) n_shift++;
        if (hen[a] === 1'b1) hen_cyc.push_back(cyc);
        if (pv[a] === 1'b1) begin
            p.x = int'(cxo[a]); p.y = int'(cyo[a]);
            pq.push_back(p);
            pv_cyc.push_back(cyc);
        end
        if (done[a] === 1'b1) begin
            n_done++;
            done_cyc = cyc;
            done_pix = pq.size();
        end
        if (req[a] === 1'b1 && prev_wait && {fx[a], fy[a], fv[a]} !== prev_addr) stab_err++;
        prev_wait = (req[a] === 1'b1) && (ack[a] !== 1'b1);
        prev_addr = {fx[a], fy[a], fv[a]};
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, expv);
        end
    endtask

    function automatic int enc_f(input fetch_t f);
        return f.x * 1000 + f.y * 100 + f.vert * 10 + f.dir;
    endfunction

    task automatic clear_rec();
        fq.delete(); pq.delete(); ack_cyc.delete(); hen_cyc.delete(); pv_cyc.delete();
        n_shift = 0; n_done = 0; done_pix = -1; done_cyc = -1; stab_err = 0; prev_wait = 0;
    endtask

    task automatic set_lat(input int l, input bit rnd);
        fixed_lat = l; cur_lat = l; rnd_lat = rnd; wcnt = 0;
    endtask

    // Scan order from the frame geometry: odd bands go right, even bands go left;
    // each fetch is the strip that enters the window on the move to the next pixel.
    task automatic build_model(input int w, input int h);
        fetch_t f;
        pix_t p, q;
        exp_f.delete(); exp_p.delete();
        for (int r = 1; r <= h - 2; r++)
            for (int k = 0; k < w - 2; k++) begin
                p.y = r;
                p.x = ((r - 1) % 2 == 0) ? 1 + k : w - 2 - k;
                exp_p.push_back(p);
            end
        for (int i = 0; i < 3; i++) begin
            f.x = i; f.y = 0; f.vert = 1; f.dir = int'(DIR_RIGHT);
            exp_f.push_back(f);
        end
        for (int i = 1; i < exp_p.size(); i++) begin
            p = exp_p[i-1]; q = exp_p[i];
            if (q.y != p.y) begin
                f.x = p.x - 1; f.y = q.y + 1; f.vert = 0; f.dir = int'(DIR_DOWN);
            end else if (q.x > p.x) begin
                f.x = q.x + 1; f.y = q.y - 1; f.vert = 1; f.dir = int'(DIR_RIGHT);
            end else begin
                f.x = q.x - 1; f.y = q.y - 1; f.vert = 1; f.dir = int'(DIR_LEFT);
            end
            exp_f.push_back(f);
        end
    endtask

    task automatic compare_frame(input int w, input int h, input string tag);
        int n;
        build_model(w, h);
        check({tag, "_fetch_count"}, fq.size(), exp_f.size());
        n = (fq.size() < exp_f.size()) ? fq.size() : exp_f.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_fetch%0d", tag, i), enc_f(fq[i]), enc_f(exp_f[i]));
        check({tag, "_pix_count"}, pq.size(), exp_p.size());
        n = (pq.size() < exp_p.size()) ? pq.size() : exp_p.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_pix%0d", tag, i), pq[i].x * 100 + pq[i].y, exp_p[i].x * 100 + exp_p[i].y);
        check({tag, "_eval_count"}, hen_cyc.size(), exp_p.size());
        check({tag, "_shift_count"}, n_shift, exp_f.size());
        check({tag, "_done_count"}, n_done, 1);
        check({tag, "_done_on_last_pix"}, done_pix, exp_p.size());
        if (pv_cyc.size() > 0) check({tag, "_done_cycle"}, done_cyc, pv_cyc[pv_cyc.size()-1]);
        check({tag, "_addr_stable"}, stab_err, 0);
        for (int i = 0; i < hen_cyc.size() && i + 2 < ack_cyc.size(); i++)
            check($sformatf("%s_eval_after_ack%0d", tag, i), hen_cyc[i], ack_cyc[i+2] + 1);
        for (int i = 0; i < pv_cyc.size() && i < hen_cyc.size(); i++)
            check($sformatf("%s_pv_after_eval%0d", tag, i), pv_cyc[i], hen_cyc[i] + 1);
    endtask

    task automatic run_frame(input bit noise, input bit spur_en);
        bit got;
        got = 0;
        clear_rec();
        @(posedge tb_clk); #1 start[act] = 1'b1;
        @(posedge tb_clk); #1 start[act] = 1'b0;
        @(negedge tb_clk);
        check("start_busy_req", {busy[act], req[act]}, 2'b11);
        for (int c = 0; c < 3000; c++) begin
            @(posedge tb_clk); #1;
            spur[act] = 1'b0;
            if (noise) start[act] = ($urandom_range(0, 3) == 0);
            @(negedge tb_clk);
            if (spur_en && hen[act] === 1'b1) spur[act] = 1'b1;
            if (done[act] === 1'b1) begin got = 1; break; end
        end
        check("done_seen", got, 1);
        @(posedge tb_clk); #1 start[act] = 1'b0; spur[act] = 1'b0;
        @(negedge tb_clk);
        if (got) check("busy_after_done", busy[act], 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        fvec_t ftbl[8];
        pvec_t ptbl[6];
        bit hit;
        ftbl = '{'{0,0,0,1,1}, '{1,1,0,1,1}, '{2,2,0,1,1}, '{3,3,0,1,1},
                 '{4,4,0,1,1}, '{5,2,3,0,3}, '{6,1,1,1,2}, '{7,0,1,1,2}};
        ptbl = '{'{0,1,1}, '{1,2,1}, '{2,3,1}, '{3,3,2}, '{4,2,2}, '{5,1,2}};
        for (int i = 0; i < NI; i++) begin start[i] = 0; spur[i] = 0; ack_r[i] = 0; end
        n_rst = 1'b0;
        clear_rec();
        repeat (3) @(posedge tb_clk);
        @(negedge tb_clk);
        for (int i = 0; i < NI; i++)
            check($sformatf("reset_outputs%0d", i),
                  {busy[i], done[i], req[i], fv[i], sh_en[i], hen[i], pv[i], sh_dir[i], fx[i], fy[i], cxo[i], cyo[i]}, '0);
        @(posedge tb_clk); #1 n_rst = 1'b1;

        // Spurious ack while idle: no shift, no start
        act = 0; set_lat(0, 0); clear_rec();
        @(posedge tb_clk); #1 spur[0] = 1'b1;
        repeat (2) @(posedge tb_clk);
        #1 spur[0] = 1'b0;
        @(negedge tb_clk);
        check("idle_ack_shift", n_shift, 0);
        check("idle_ack_busy", busy[0], 1'b0);

        // 5x4 zero-wait against fixed tables
        run_frame(0, 0);
        check("tbl_fetch_count", fq.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < fq.size())
                check($sformatf("tbl_fetch%0d", ftbl[i].idx), enc_f(fq[i]),
                      ftbl[i].x * 1000 + ftbl[i].y * 100 + ftbl[i].vert * 10 + ftbl[i].dir);
        check("tbl_pix_count", pq.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < pq.size())
                check($sformatf("tbl_pix%0d", ptbl[i].idx), pq[i].x * 100 + pq[i].y, ptbl[i].x * 100 + ptbl[i].y);
        check("tbl_done_on_sixth", done_pix, 6);
        for (int i = 0; i + 1 < pv_cyc.size(); i++)
            check($sformatf("tbl_throughput%0d", i), pv_cyc[i+1] - pv_cyc[i], 2);
        compare_frame(5, 4, "w5h4_lat0");

        // Slow source: three wait cycles per request
        set_lat(3, 0);
        run_frame(0, 0);
        compare_frame(5, 4, "w5h4_lat3");

        // start while busy and acks in EVAL must be ignored
        set_lat(1, 0);
        run_frame(1, 1);
        compare_frame(5, 4, "w5h4_noise");

        // Asynchronous reset in the middle of a fetch wait
        set_lat(3, 0); clear_rec();
        @(posedge tb_clk); #1 start[0] = 1'b1;
        @(posedge tb_clk); #1 start[0] = 1'b0;
        hit = 0;
        for (int c = 0; c < 500; c++) begin
            @(negedge tb_clk);
            if (pq.size() >= 2 && req[0] === 1'b1 && ack[0] !== 1'b1) begin hit = 1; break; end
        end
        check("reset_reach_fetch", hit, 1);
        #1 n_rst = 1'b0;
        #1;
        check("midframe_reset_outputs",
              {busy[0], done[0], req[0], fv[0], sh_en[0], hen[0], pv[0], sh_dir[0], fx[0], fy[0], cxo[0], cyo[0]}, '0);
        repeat (2) @(posedge tb_clk);
        @(negedge tb_clk);
        check("midframe_reset_no_done", n_done, 0);
        check("midframe_reset_busy", busy[0], 1'b0);
        @(posedge tb_clk); #1 n_rst = 1'b1;
        set_lat(0, 0);
        run_frame(0, 0);
        if (fq.size() > 0) check("restart_first_fetch", enc_f(fq[0]), 11);
        compare_frame(5, 4, "w5h4_restart");

        // Minimum 3x3 frame
        act = 1; set_lat(0, 0);
        run_frame(0, 0);
        compare_frame(3, 3, "w3h3");

        // Randomized ack latency and start noise on 7x6 frames
        act = 2; set_lat(0, 1);
        for (int k = 0; k < 3; k++) begin
            run_frame(1, k[0]);
            compare_frame(7, 6, $sformatf("w7h6_rnd%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/window_scan_ctrl.md
# window_scan_ctrl

Sequencing controller for the 3x3 pixel window buffer and hysteresis stage of the edge-detector pipeline. It walks the window over an IMG_W x IMG_H frame in serpentine order: right along a row band, down one row, left along the next. For each move it fetches the 3-pixel strip from the pixel source, drives the buffer's shift controls, pulses hysteresis_enable once per interior pixel, and reports the evaluated pixel's centre coordinates to the consumer.

## Interface
- IMG_W, 64, frame width in pixels (>= 3)
- IMG_H, 64, frame height in pixels (>= 3)
- CW, $clog2(max(IMG_W,IMG_H)), coordinate width
- clk  in  1  system clock, rising edge
- n_rst  in  1  reset; one clock, asynchronous, active-low
- start  in  1  begin frame scan; sampled only in IDLE
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse at end of frame
- fetch_req  out  1  strip request, held until fetch_ack
- fetch_x, fetch_y  out  CW  first pixel of the requested strip
- fetch_vert  out  1  1: column strip (x, y..y+2); 0: row strip (x..x+2, y)
- fetch_ack  in  1  strip valid on buffer_input this cycle
- shift_enable  out  1  window shift strobe
- shift_direction  out  2  00 hold, 01 right, 10 left, 11 down
- hysteresis_enable  out  1  evaluate the current window
- center_x, center_y  out  CW  centre of the current window
- pix_valid  out  1  hysteresis_out belongs to (center_x, center_y)

## Operation
- States: IDLE, FETCH, EVAL, DONE.
- Transitions:
  - IDLE -> FETCH on start.
  - In FETCH, fetch_req = 1. On fetch_ack, shift_enable = fetch_ack combinationally. Next state is EVAL if the window is full, otherwise FETCH (priming).
  - EVAL -> FETCH. If the EVAL is for the last pixel, EVAL -> DONE instead.
  - DONE -> IDLE.
- Priming: column strips x = 0, 1, 2 at y = 0, direction 01. No EVAL after the first two. The centre becomes (1,1) after the third.
- Rightward pass (centre cx): fetch column x = cx+2, y = cy-1, direction 01; cx increments.
- Row end: when cx = IMG_W-2 going right, or cx = 1 going left:
  - If cy = IMG_H-2 the frame is finished (DONE).
  - Otherwise fetch row strip x = cx-1, y = cy+2, vert = 0, direction 11; cy increments; the pass direction toggles.
- Leftward pass: fetch column x = cx-2, y = cy-1, direction 10; cx decrements.
- Output counts:
  - EVAL count per frame = (IMG_W-2)(IMG_H-2).
  - Fetch count = that + 2.
- Ignored inputs:
  - start while busy is ignored.
  - fetch_ack outside FETCH is ignored.
- shift_direction = 00 whenever shift_enable = 0.

## Timing
- Reset (async, n_rst = 0): state IDLE. All outputs 0, including the coordinates and the pass direction flag (right).
- Release of reset is synchronous to clk.
- start at edge k: FETCH and fetch_req high in cycle k+1.
- Ack at edge t:
  - Shift happens at edge t.
  - center_x/center_y update at edge t.
  - hysteresis_enable is high in cycle t+1 (EVAL).
  - pix_valid is high in cycle t+2, with the coordinates still those of the evaluated window.
- Sustained throughput: one pixel per 2 cycles with zero-wait ack.
- done is asserted in the same cycle as the last pix_valid; busy falls in the following cycle.
- Reset mid-frame: immediate abort to IDLE. The outstanding request is dropped and no done pulse is generated.

## Structure
- scan_pkg holds:
  - dir_t enum: DIR_HOLD = 2'b00, DIR_RIGHT = 2'b01, DIR_LEFT = 2'b10, DIR_DOWN = 2'b11.
  - state_t enum.
- One sub-module, scan_coord_gen, holds:
  - the centre counters and the pass-direction flag;
  - the row-end / last-pixel detection;
  - fetch address generation.
- FSM and strobes live in window_scan_ctrl.

## Test plan
- Reset: hold n_rst = 0 mid-FETCH -> all outputs 0 immediately; no done; the next start restarts at fetch (0,0).
- IMG_W = 5, IMG_H = 4, zero-wait ack, each stimulus -> required response:
  - Fetch sequence -> (x,y,vert,dir) = (0,0,1,01) (1,0,1,01) (2,0,1,01) (3,0,1,01) (4,0,1,01) (2,3,0,11) (1,1,1,10) (0,1,1,10).
  - pix_valid centres -> (1,1) (2,1) (3,1) (3,2) (2,2) (1,2).
  - Completion -> done on the sixth pix_valid.
- Ack latency 3 cycles -> fetch_req and fetch coordinates stable until ack; exactly one shift_enable per ack; hysteresis_enable exactly one cycle after each post-priming ack.
- start pulsed while busy, plus a spurious fetch_ack in EVAL -> no restart, no extra shift, and the EVAL count stays at 6.
- IMG_W = IMG_H = 3 -> three fetches, one EVAL at (1,1), then done; busy is low in the next cycle.
